// File: rtl/buffer_seq_165_if.sv
// buffer_seq_165_if: producer stream, sample-buffer port and filter tap stream of the sequencer.
// BUF_SEQ_BLKCNT_EN adds the blk_count signal.
interface buffer_seq_165_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [3:0] buf_addr_sel;
  logic [7:0] buf_data_in;
  logic       buf_write_en;
  logic       buf_read_en;
  logic [7:0] buf_data_out;
  logic       tap_ready;
  logic       tap_valid;
  logic [7:0] tap_data;
  logic       tap_first;
  logic       tap_last;
  logic [1:0] tap_win;
`ifdef BUF_SEQ_BLKCNT_EN
  logic [7:0] blk_count;
  modport master (input in_valid, in_data, buf_data_out, tap_ready,
                  output in_ready, buf_addr_sel, buf_data_in, buf_write_en, buf_read_en,
                  tap_valid, tap_data, tap_first, tap_last, tap_win, blk_count);
  modport slave (output in_valid, in_data, buf_data_out, tap_ready,
                 input in_ready, buf_addr_sel, buf_data_in, buf_write_en, buf_read_en,
                 tap_valid, tap_data, tap_first, tap_last, tap_win, blk_count);
`else
  modport master (input in_valid, in_data, buf_data_out, tap_ready,
                  output in_ready, buf_addr_sel, buf_data_in, buf_write_en, buf_read_en,
                  tap_valid, tap_data, tap_first, tap_last, tap_win);
  modport slave (output in_valid, in_data, buf_data_out, tap_ready,
                 input in_ready, buf_addr_sel, buf_data_in, buf_write_en, buf_read_en,
                 tap_valid, tap_data, tap_first, tap_last, tap_win);
`endif
endinterface

// File: rtl/buffer_seq_165.sv
// buffer_seq_165: fills the 9-entry sample buffer, then reads it back as N_OUT overlapping windows.
// Optional BUF_SEQ_BLKCNT_EN adds a wrapping count of completed blocks.
module buffer_seq_165 #(
  parameter int N_OUT = 4,
  parameter int TAPS  = 6
) (
  input  logic              clk,
  input  logic              rst_async_n,
  buffer_seq_165_if.master  bus
);
  localparam int DEPTH = N_OUT + TAPS - 1;
  localparam logic [1:0] S_IDLE = 2'd0, S_FILL = 2'd1, S_READ = 2'd2;
  logic [1:0] r_state;
  logic [3:0] r_fill_cnt;
  logic [1:0] r_win;
  logic [2:0] r_tap;
  logic       r_tap_valid, r_tap_first, r_tap_last;
  logic [1:0] r_tap_win;
  logic       w_wr, w_rd, w_tap_end, w_fill_end, w_blk_end;
  always_comb begin
    w_wr       = r_state == S_FILL && bus.in_valid;
    w_rd       = r_state == S_READ && bus.tap_ready;
    w_tap_end  = r_tap == 3'(TAPS - 1);
    w_fill_end = r_fill_cnt == 4'(DEPTH - 1);
    w_blk_end  = w_rd && w_tap_end && r_win == 2'(N_OUT - 1);
  end
  assign bus.in_ready     = r_state == S_FILL;
  assign bus.buf_write_en = w_wr;
  assign bus.buf_read_en  = w_rd;
  assign bus.buf_addr_sel = w_wr ? r_fill_cnt : w_rd ? 4'(r_win) + 4'(r_tap) : '0;
  assign bus.buf_data_in  = w_wr ? bus.in_data : '0;
  assign bus.tap_data     = bus.buf_data_out;
  assign bus.tap_valid    = r_tap_valid;
  assign bus.tap_first    = r_tap_first;
  assign bus.tap_last     = r_tap_last;
  assign bus.tap_win      = r_tap_win;
  // Tap framing is registered to line up with the buffer's one-cycle read latency.
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      r_state     <= S_IDLE;
      r_fill_cnt  <= '0;
      r_win       <= '0;
      r_tap       <= '0;
      r_tap_valid <= 1'b0;
      r_tap_first <= 1'b0;
      r_tap_last  <= 1'b0;
      r_tap_win   <= '0;
    end else begin
      if (r_state == S_IDLE) r_state <= S_FILL;
      if (w_wr) begin
        r_fill_cnt <= w_fill_end ? '0 : r_fill_cnt + 4'd1;
        if (w_fill_end) r_state <= S_READ;
      end
      if (w_rd) begin
        r_tap <= w_tap_end ? '0 : r_tap + 3'd1;
        if (w_tap_end) r_win <= w_blk_end ? '0 : r_win + 2'd1;
        if (w_blk_end) r_state <= S_FILL;
        r_tap_win <= r_win;
      end
      r_tap_valid <= w_rd;
      r_tap_first <= w_rd && r_tap == 3'd0;
      r_tap_last  <= w_rd && w_tap_end;
    end
  end
`ifdef BUF_SEQ_BLKCNT_EN
  logic [7:0] r_blk_count;
  assign bus.blk_count = r_blk_count;
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) r_blk_count <= '0;
    else if (w_blk_end) r_blk_count <= r_blk_count + 8'd1;
  end
`endif
endmodule

// File: tb/tb_buffer_seq_165.sv
// tb_buffer_seq_165: random and directed stimulus against a queue-based block/window model.
module tb_buffer_seq_165;
  typedef struct packed {logic [7:0] d; logic f; logic l; logic [1:0] w;} tap_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  buffer_seq_165_if bus();
  buffer_seq_165 dut (.clk(clk), .rst_async_n(rst_n), .bus(bus));

  logic [7:0] mem [0:15];
  logic [7:0] rdata = 8'h00;
  assign bus.buf_data_out = rdata;
  always @(posedge clk) begin
    if (bus.buf_write_en) mem[bus.buf_addr_sel] <= bus.buf_data_in;
    if (bus.buf_read_en) rdata <= mem[bus.buf_addr_sel];
  end

  int errors = 0, checks = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [7:0] stream [0:4095];
  int   issue_q[$];
  tap_t tap_q[$];
  logic [7:0] blk [0:8];
  tap_t tlog [0:63];
  int ntap = 0, acc = 0, wr_cnt = 0, issued_in_blk = 0, blocks_done = 0, cyc = 0;
  int vmode = 0, rmode = 0, stall_cnt = 0, post_rst_addr = 99;
  bit stall_en = 0, after_rst = 0, co_flag = 0, prev_iss = 0;
  logic [7:0] exp_blk = 8'd0;

  always @(negedge clk) begin
    bit exp_ready, wr, iss;
    tap_t t;
    if (!rst_n) begin
      issue_q.delete(); tap_q.delete();
      wr_cnt = 0; issued_in_blk = 0; cyc = 0; prev_iss = 0; exp_blk = 8'd0;
    end else begin
      if (cyc < 1000) cyc++;
      exp_ready = cyc >= 1 && issue_q.size() == 0;
      chk("in_ready", bus.in_ready, exp_ready);
      wr = bus.in_valid && exp_ready;
      iss = issue_q.size() > 0 && bus.tap_ready;
      chk("buf_write_en", bus.buf_write_en, wr);
      chk("buf_read_en", bus.buf_read_en, iss);
      if (wr) begin
        chk("wr_addr", bus.buf_addr_sel, wr_cnt);
        chk("wr_data", bus.buf_data_in, bus.in_data);
        if (after_rst) begin post_rst_addr = bus.buf_addr_sel; after_rst = 0; end
      end
      if (iss) begin
        chk("rd_addr", bus.buf_addr_sel, issue_q.pop_front());
        issued_in_blk++;
      end
      if (!wr && !iss) chk("idle_addr", bus.buf_addr_sel, 0);
      chk("tap_valid", bus.tap_valid, prev_iss);
      if (bus.tap_valid && prev_iss && tap_q.size() > 0) begin
        t = tap_q.pop_front();
        chk("tap", {bus.tap_data, bus.tap_first, bus.tap_last, bus.tap_win}, t);
        if (ntap < 64) tlog[ntap] = {bus.tap_data, bus.tap_first, bus.tap_last, bus.tap_win};
        ntap++;
        if (t.l && t.w == 2'd3) begin
          if (blocks_done == 0) co_flag = bus.buf_write_en && bus.buf_addr_sel == 4'd0;
          blocks_done++;
        end
      end
`ifdef BUF_SEQ_BLKCNT_EN
      chk("blk_count", bus.blk_count, exp_blk);
      if (iss && issue_q.size() == 0) exp_blk = exp_blk + 8'd1;
`endif
      if (wr) begin
        blk[wr_cnt] = bus.in_data;
        wr_cnt++; acc++;
        if (wr_cnt == 9) begin
          for (int w = 0; w < 4; w++)
            for (int k = 0; k < 6; k++) begin
              issue_q.push_back(w + k);
              tap_q.push_back({blk[w + k], k == 0, k == 5, 2'(w)});
            end
          wr_cnt = 0; issued_in_blk = 0;
        end
      end
      prev_iss = iss;
    end
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.tap_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.in_valid = vmode == 0 ? 1'b1 : vmode == 1 ? ~bus.in_valid : ($urandom_range(0, 3) != 0);
      bus.in_data = stream[acc % 4096];
      if (stall_en && issued_in_blk == 9 && stall_cnt < 3) begin
        bus.tap_ready = 1'b0; stall_cnt++;
      end else bus.tap_ready = rmode == 0 ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #600000;
    errors++; checks++;
    $display("FAIL timeout: blocks_done=%0d", blocks_done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int n_first, n_last, target;
`ifdef BUF_SEQ_BLKCNT_EN
    target = 262;
`else
    target = 20;
`endif
    for (int i = 0; i < 4096; i++) stream[i] = 8'($urandom);
    for (int i = 0; i < 9; i++) begin
      stream[i] = 8'h10 + 8'(i);
      stream[9 + i] = 8'h20 + 8'(i);
    end
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    wait (acc >= 18);
    stall_en = 1; vmode = 1;
    wait (blocks_done >= 2);
    n_first = 0; n_last = 0;
    for (int i = 0; i < 24; i++) begin
      n_first += int'(tlog[i].f);
      n_last += int'(tlog[i].l);
    end
    chk("blk1_w0_first", tlog[0], {8'h10, 1'b1, 1'b0, 2'd0});
    chk("blk1_w0_last", tlog[5], {8'h15, 1'b0, 1'b1, 2'd0});
    chk("blk1_w3_first", tlog[18], {8'h13, 1'b1, 1'b0, 2'd3});
    chk("blk1_w3_last", tlog[23], {8'h18, 1'b0, 1'b1, 2'd3});
    chk("blk1_first_cnt", n_first, 4);
    chk("blk1_last_cnt", n_last, 4);
    chk("b2b_write_addr0", co_flag, 1);
    chk("blk2_w0_first", tlog[24].d, 8'h20);
    chk("blk2_w0_last", tlog[29].d, 8'h25);
    chk("after_stall_tap", tlog[33], {8'h24, 1'b0, 1'b0, 2'd1});
    chk("stall_cycles", stall_cnt, 3);
    wait (acc >= 27);
    vmode = 2;
    wait (acc >= 36 && issued_in_blk >= 13);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_enables", {bus.buf_write_en, bus.buf_read_en}, 0);
    chk("rst_addr_data", {bus.buf_addr_sel, bus.buf_data_in}, 0);
    chk("rst_tap_flags", {bus.tap_valid, bus.tap_first, bus.tap_last}, 0);
    chk("rst_tap_win", bus.tap_win, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    after_rst = 1; rmode = 1;
    wait (blocks_done >= target);
    chk("post_rst_first_addr", post_rst_addr, 0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
